// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Owns the architectural PC and the instruction-fetch handshake of the
//   multi-cycle CPU. It fetches the word at pc into the instruction register,
//   then holds it until the main control FSM commits the next PC. The next PC
//   is pc+4, the branch target, the jump target or the jr target.
//
//   Build option: define PC_ALIGN_CHECK_EN to trap misaligned next-PC targets.
//   With the trap, the PC is redirected to EXC_PC, epc captures the bad target
//   and pc_exc pulses for one cycle. Without it, target bits [1:0] are cleared
//   and pc_exc/epc read as zero.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | if_req high; waiting for if_ack to latch if_rdata into ir
//   EXEC   | ir valid and held; waiting for pc_wr to commit the next PC

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_wr,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [31:0] bpc,
   input  logic [31:0] jpc,
   input  logic [31:0] jrpc,
   output logic        if_req,
   output logic [31:0] if_addr,
   input  logic        if_ack,
   input  logic [31:0] if_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic        pc_exc,
   output logic [31:0] epc
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_EXEC  = 1'b1
   } state_t;

   localparam logic [1:0] SEL_PC4 = 2'b00;
   localparam logic [1:0] SEL_BR  = 2'b01;
   localparam logic [1:0] SEL_J   = 2'b10;
   localparam logic [1:0] SEL_JR  = 2'b11;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] npc_raw;

   // Combinational pc+4 and the raw next-PC target before any alignment handling.
   always_comb begin
      pc4     = pc_q + 32'd4;
      npc_raw = pc4;
      unique case (npc_sel)
         SEL_PC4: npc_raw = pc4;
         SEL_BR:  npc_raw = br_taken ? bpc : pc4;
         SEL_J:   npc_raw = jpc;
         SEL_JR:  npc_raw = jrpc;
         default: npc_raw = pc4;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   logic        exc_q, exc_d;
   logic [31:0] epc_q, epc_d;
   logic        npc_misaligned;

   assign npc_misaligned = (npc_raw[1:0] != 2'b00);

   // Next-state and datapath update; a misaligned commit redirects to EXC_PC.
   always_comb begin
      state_nxt = state;
      pc_d      = pc_q;
      ir_d      = ir_q;
      exc_d     = 1'b0;
      epc_d     = epc_q;
      unique case (state)
         S_FETCH: begin
            if (if_ack) begin
               ir_d      = if_rdata;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (pc_wr) begin
               state_nxt = S_FETCH;
               if (npc_misaligned) begin
                  pc_d  = EXC_PC;
                  epc_d = npc_raw;
                  exc_d = 1'b1;
               end else begin
                  pc_d = npc_raw;
               end
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   // Exception pulse and captured target; epc holds until the next trap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_q <= 1'b0;
         epc_q <= 32'h0;
      end else begin
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   assign pc_exc = exc_q;
   assign epc    = epc_q;
`else
   logic unused_align;

   // Without the trap the low target bits are simply dropped.
   assign unused_align = ^{EXC_PC, npc_raw[1:0]};

   // Next-state and datapath update with word-aligned next PC.
   always_comb begin
      state_nxt = state;
      pc_d      = pc_q;
      ir_d      = ir_q;
      unique case (state)
         S_FETCH: begin
            if (if_ack) begin
               ir_d      = if_rdata;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (pc_wr) begin
               state_nxt = S_FETCH;
               pc_d      = {npc_raw[31:2], 2'b00};
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   assign pc_exc = 1'b0;
   assign epc    = 32'h0;
`endif

   // State, PC and instruction register; reset returns to a fresh fetch at RESET_PC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         pc_q  <= RESET_PC;
         ir_q  <= 32'h0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
      end
   end

   assign pc       = pc_q;
   assign if_addr  = pc_q;
   assign ir       = ir_q;
   assign ir_valid = (state == S_EXEC);
   assign if_req   = (state == S_FETCH) & ~reset;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus updates a behavioural model at
// each rising edge and queues the expected outputs; a monitor compares them
// 2 time units after the edge.

module tb_pc_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_wr = 1'b0;
   logic [1:0]  npc_sel = 2'b00;
   logic        br_taken = 1'b0;
   logic [31:0] bpc = 32'h0, jpc = 32'h0, jrpc = 32'h0;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack = 1'b0;
   logic [31:0] if_rdata = 32'h0;
   logic [31:0] pc, pc4, ir, epc;
   logic        ir_valid, pc_exc;

   pc_fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
      .clk(clk), .reset(reset), .pc_wr(pc_wr), .npc_sel(npc_sel),
      .br_taken(br_taken), .bpc(bpc), .jpc(jpc), .jrpc(jrpc),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .pc(pc), .pc4(pc4), .ir(ir), .ir_valid(ir_valid),
      .pc_exc(pc_exc), .epc(epc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        if_req;
      logic        ir_valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] ir;
      logic        pc_exc;
      logic [31:0] epc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // model: "waiting" means an instruction is still being fetched
   bit          m_waiting = 1'b1;
   logic [31:0] m_pc = RESET_PC, m_ir = 32'h0, m_epc = 32'h0;
   bit          m_exc = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model_edge();
      logic [31:0] tgt;
      if (reset) begin
         m_waiting = 1'b1; m_pc = RESET_PC; m_ir = 32'h0; m_exc = 1'b0; m_epc = 32'h0;
         return;
      end
      m_exc = 1'b0;
      if (m_waiting) begin
         if (if_ack) begin
            m_ir = if_rdata;
            m_waiting = 1'b0;
         end
      end else if (pc_wr) begin
         if (npc_sel == 2'd0)      tgt = m_pc + 32'd4;
         else if (npc_sel == 2'd1) tgt = br_taken ? bpc : m_pc + 32'd4;
         else if (npc_sel == 2'd2) tgt = jpc;
         else                      tgt = jrpc;
`ifdef PC_ALIGN_CHECK_EN
         if (tgt % 4 != 0) begin
            m_pc = EXC_PC; m_epc = tgt; m_exc = 1'b1;
         end else begin
            m_pc = tgt;
         end
`else
         m_pc = tgt - (tgt % 4);
`endif
         m_waiting = 1'b1;
      end
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.if_req   = m_waiting && !reset;
      e.ir_valid = !m_waiting;
      e.pc       = m_pc;
      e.pc4      = m_pc + 32'd4;
      e.ir       = m_ir;
      e.pc_exc   = m_exc;
      e.epc      = m_epc;
      exp_q.push_back(e);
   endfunction

   task automatic cyc(input bit rst, input bit ack, input logic [31:0] rd, input bit wr,
                      input logic [1:0] sel, input bit bt, input logic [31:0] b,
                      input logic [31:0] j, input logic [31:0] r);
      @(negedge clk);
      reset = rst; if_ack = ack; if_rdata = rd; pc_wr = wr;
      npc_sel = sel; br_taken = bt; bpc = b; jpc = j; jrpc = r;
      @(posedge clk);
      model_edge();
      push_exp();
   endtask

   // Monitor: compare DUT outputs against the queued expectation for this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_req",   {31'h0, if_req},   {31'h0, e.if_req});
            chk("if_addr",  if_addr,           e.pc);
            chk("ir_valid", {31'h0, ir_valid}, {31'h0, e.ir_valid});
            chk("pc",       pc,                e.pc);
            chk("pc4",      pc4,               e.pc4);
            chk("ir",       ir,                e.ir);
            chk("pc_exc",   {31'h0, pc_exc},   {31'h0, e.pc_exc});
            chk("epc",      epc,               e.epc);
         end
      end
   end

   // Stimulus: directed test-plan sequence, mid-EXEC reset, then random traffic.
   initial begin
      logic [31:0] t;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 chk("rst_if_addr", if_addr, 32'h0000_3000);
      cyc(0, 1, 32'h2408_0005, 0, 0, 0, 0, 0, 0);
      #2 chk("first_ir", ir, 32'h2408_0005);
      cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0);
      #2 chk("seq_pc", pc, 32'h0000_3004);
      // wait states with pc_wr pulses during FETCH
      cyc(0, 0, 32'hDEAD_BEEF, 1, 2'd2, 0, 0, 32'h0000_7000, 0);
      cyc(0, 0, 32'hDEAD_BEEF, 1, 2'd3, 0, 0, 0, 32'h0000_7100);
      cyc(0, 0, 32'hDEAD_BEEF, 1, 2'd0, 0, 0, 0, 0);
      cyc(0, 1, 32'h1111_2222, 0, 0, 0, 0, 0, 0);
      // branch taken / not taken
      cyc(0, 1, 32'h5555_5555, 1, 2'd1, 1, 32'h0000_3040, 32'h0000_5000, 32'h0000_6000);
      #2 chk("br_taken_pc", pc, 32'h0000_3040);
      cyc(0, 1, 32'h3333_4444, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 2'd1, 0, 32'h0000_3080, 32'h0000_5000, 32'h0000_6000);
      #2 chk("br_not_taken_pc", pc, 32'h0000_3044);
      cyc(0, 1, 32'h0000_0001, 0, 0, 0, 0, 0, 0);
      // jump, jr to top of memory, wrap
      cyc(0, 0, 0, 1, 2'd2, 1, 32'h0000_3100, 32'h0040_0000, 32'h0000_6000);
      cyc(0, 1, 32'h0000_0002, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 2'd3, 1, 32'h0000_3100, 32'h0000_5000, 32'hFFFF_FFFC);
      cyc(0, 1, 32'h0000_0003, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 2'd0, 0, 0, 0, 0);
      #2 chk("wrap_pc", pc, 32'h0000_0000);
      cyc(0, 1, 32'h0000_0004, 0, 0, 0, 0, 0, 0);
      // misaligned jr
      cyc(0, 0, 0, 1, 2'd3, 0, 0, 0, 32'h0000_3006);
`ifdef PC_ALIGN_CHECK_EN
      #2 chk("misalign_pc", pc, EXC_PC);
`else
      #2 chk("misalign_pc", pc, 32'h0000_3004);
`endif
      cyc(0, 1, 32'h0000_0005, 0, 0, 0, 0, 0, 0);
      // asynchronous reset while in EXEC
      @(negedge clk);
      reset = 1'b1; if_ack = 1'b1; pc_wr = 1'b1;
      #1;
      chk("async_pc",       pc, RESET_PC);
      chk("async_ir",       ir, 32'h0);
      chk("async_ir_valid", {31'h0, ir_valid}, 32'h0);
      chk("async_if_req",   {31'h0, if_req}, 32'h0);
      @(posedge clk);
      model_edge();
      push_exp();
      cyc(1, 1, 32'h9999_9999, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         t = $urandom();
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 2) != 0), $urandom(),
             ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1),
             {$urandom(), 2'b00} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0),
             {t[29:0], 2'b00},
             $urandom() & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #4;
      chk("queue_drained", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
